mem_access_ctrl: RTL

Request-side controller sitting directly upstream of the 16x8 single-port data RAM in the simple processor. It accepts load/store requests from the core over a valid/ready handshake and drives the RAM address, write data, write enable and read enable. It absorbs the RAM's one-cycle registered read latency and returns load data over a valid/ready response channel. It also provides a fill sequencer that writes a constant to every RAM location.

---
 rtl/mem_access_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Request-side controller for a single-port data RAM: core load/store handshake,
// registered RAM strobes, one-cycle read-latency absorption and a constant-fill sweep.
module mem_access_ctrl #(
    parameter int unsigned        ADDR_W = 4,
    parameter int unsigned        DATA_W = 8,
    parameter logic [DATA_W-1:0]  FILL   = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    input  logic              init_start,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_dataIn,
    output logic              ram_we,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_dataOut
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WRITE   = 3'd1;
    localparam logic [2:0] READ    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;
    localparam logic [2:0] INIT    = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_rd_q, ram_rd_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // init_start wins over a same-cycle request, so the request must not see ready.
    assign req_ready = (state_q == IDLE) && !init_start;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        ram_address_d = ram_address_q;
        ram_data_in_d = ram_data_in_q;
        ram_we_d      = 1'b0;
        ram_rd_d      = 1'b0;
        resp_valid_d  = resp_valid_q;
        resp_data_d   = resp_data_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                if (init_start) begin
                    state_d       = INIT;
                    ram_we_d      = 1'b1;
                    ram_address_d = '0;
                    ram_data_in_d = FILL;
                    cnt_d         = '0;
                end else if (req_valid) begin
                    ram_address_d = req_addr;
                    if (req_write) begin
                        state_d       = WRITE;
                        ram_we_d      = 1'b1;
                        ram_data_in_d = req_wdata;
                    end else begin
                        state_d  = READ;
                        ram_rd_d = 1'b1;
                    end
                end
            end
            WRITE: state_d = IDLE;
            READ:  state_d = CAPTURE;
            CAPTURE: begin
                // RAM registered its output on the READ edge; it is valid now.
                resp_data_d  = ram_dataOut;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d         = cnt_q + 1'b1;
                    ram_address_d = cnt_q + 1'b1;
                    ram_data_in_d = FILL;
                    ram_we_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ram_address_q <= '0;
            ram_data_in_q <= '0;
            ram_we_q      <= 1'b0;
            ram_rd_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            ram_address_q <= ram_address_d;
            ram_data_in_q <= ram_data_in_d;
            ram_we_q      <= ram_we_d;
            ram_rd_q      <= ram_rd_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            cnt_q         <= cnt_d;
        end
    end

    assign ram_address = ram_address_q;
    assign ram_dataIn  = ram_data_in_q;
    assign ram_we      = ram_we_q;
    assign ram_rd      = ram_rd_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;

endmodule
